// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin arbiter in front of one shared DW-bit register.
// Each edge, at most one requesting client wins and its write data is
// captured into o_q. o_gnt reports that winner for the following cycle.
// A winner that holds i_lock keeps the register for up to MAX_BURST
// back-to-back writes.
//
// Handshake: i_req is a level valid. The edge at which client n wins is the
// edge at which its i_wdata is written. o_gnt[n] is high for exactly the
// cycle after that edge. A client that keeps i_req high through that cycle
// competes again at the next edge, so it must drop i_req or present new data
// while its grant is visible.
//
// FSM state is visible on o_busy (high while LOCKED).
//
// Optional build macro: ARB_STATS_EN adds o_wr_cnt, a 16-bit saturating
// count of register writes.
module rr_reg_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_lock,
  input  logic [NUM_REQ*DW-1:0]      i_wdata,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [DW-1:0]              o_q,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
`ifdef ARB_STATS_EN
  output logic [15:0]                o_wr_cnt,
`endif
  output logic                       o_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        ptr, ptr_n;
  logic [IW-1:0]        owner_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  logic                 wr;
  logic [IW-1:0]        wsel;
  logic [NUM_REQ-1:0]   gnt_n;
  logic                 do_search;
  logic [IW-1:0]        start;
  logic [IW:0]          srch;
  logic [DW-1:0]        wdata_sel;

  // Index after i, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // First requesting client at or after start, wrapping; MSB flags a hit.
  function automatic logic [IW:0] find_first(input logic [NUM_REQ-1:0] req,
                                             input logic [IW-1:0]      from);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(from) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  // Next-state, winner selection and write enable.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    bcnt_n    = bcnt;
    owner_n   = o_owner;
    wr        = 1'b0;
    wsel      = o_owner;
    gnt_n     = '0;
    do_search = 1'b0;
    start     = ptr;
    srch      = '0;

    case (state)
      IDLE: begin
        do_search = 1'b1;
        start     = ptr;
      end
      LOCKED: begin
        if (i_req[o_owner]) begin
          wr   = 1'b1;
          wsel = o_owner;
          if (i_lock[o_owner] && (bcnt < BW'(MAX_BURST - 1))) begin
            bcnt_n = bcnt + 1'b1;
          end else begin
            // Burst exhausted or lock dropped: this is the owner's last write.
            state_n = IDLE;
            ptr_n   = next_idx(o_owner);
            bcnt_n  = '0;
          end
        end else begin
          // Owner released early: arbitrate among the others in this same edge.
          state_n   = IDLE;
          bcnt_n    = '0;
          ptr_n     = next_idx(o_owner);
          do_search = 1'b1;
          start     = next_idx(o_owner);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (do_search) begin
      srch = find_first(i_req, start);
      if (srch[IW]) begin
        wr   = 1'b1;
        wsel = srch[IW-1:0];
        if (i_lock[wsel] && (MAX_BURST > 1)) begin
          // Pointer stays put while locked; it advances when the lock ends.
          state_n = LOCKED;
          bcnt_n  = BW'(1);
          ptr_n   = start;
        end else begin
          ptr_n = next_idx(wsel);
        end
      end
    end

    if (wr) begin
      gnt_n[wsel] = 1'b1;
      owner_n     = wsel;
    end
  end

  assign wdata_sel = i_wdata[int'(wsel)*DW +: DW];

  // State, pointer, burst count and the shared register itself.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      ptr     <= '0;
      bcnt    <= '0;
      o_gnt   <= '0;
      o_q     <= '0;
      o_owner <= '0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      bcnt    <= bcnt_n;
      o_gnt   <= gnt_n;
      o_owner <= owner_n;
      o_busy  <= (state_n == LOCKED);
      if (wr) o_q <= wdata_sel;
    end
  end

`ifdef ARB_STATS_EN
  // Saturating count of edges that wrote the register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_wr_cnt <= '0;
    end else if (wr && (o_wr_cnt != 16'hFFFF)) begin
      o_wr_cnt <= o_wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: directed bench for rr_reg_arbiter (4 clients, 8-bit
// data, bursts of 4). Inputs change 1 time unit after a rising edge; outputs
// are checked at that same point, so they reflect the edge just taken.
module tb_rr_reg_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [7:0] wd [4];
  logic [31:0] wdata;
  logic [3:0] gnt;
  logic [7:0] q;
  logic [1:0] owner;
  logic       busy;
`ifdef ARB_STATS_EN
  logic [15:0] wr_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  assign wdata = {wd[3], wd[2], wd[1], wd[0]};

  rr_reg_arbiter #(.NUM_REQ(4), .DW(8), .MAX_BURST(4)) dut (
    .i_clk   (clk),
    .i_rstn  (rst_n),
    .i_req   (req),
    .i_lock  (lock),
    .i_wdata (wdata),
    .o_gnt   (gnt),
    .o_q     (q),
    .o_owner (owner),
`ifdef ARB_STATS_EN
    .o_wr_cnt(wr_cnt),
`endif
    .o_busy  (busy)
  );

  // Clock and reset-free clock generator.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_data();
    for (int n = 0; n < 4; n++) wd[n] = 8'h10 + 8'(n);
  endtask

  task automatic test_reset();
    logic [3:0] eg [2] = '{4'b0001, 4'b0010};
    logic [7:0] eq [2] = '{8'h10, 8'h11};
    rst_n = 1'b0; req = '0; lock = '0; set_default_data();
    step(); step();
    n_cmp++;
    if ({gnt, q, owner, busy} !== 15'd0) begin
      n_fail++; $display("FAIL reset_init: got gnt=%b q=%h owner=%0d busy=%b required all 0", gnt, q, owner, busy);
    end
    rst_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (gnt !== eg[k] || q !== eq[k]) begin
        n_fail++; $display("FAIL reset_pre[%0d]: got gnt=%b q=%h required gnt=%b q=%h", k, gnt, q, eg[k], eq[k]);
      end
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, q, owner, busy} !== 15'd0) begin
      n_fail++; $display("FAIL reset_async: got gnt=%b q=%h owner=%0d busy=%b required all 0", gnt, q, owner, busy);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || q !== 8'h00) begin
        n_fail++; $display("FAIL reset_hold[%0d]: got gnt=%b q=%h required gnt=0000 q=00", k, gnt, q);
      end
    end
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] eq [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [1:0] eo [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    set_default_data();
    req = 4'b1111; lock = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (gnt !== eg[k] || q !== eq[k] || owner !== eo[k] || busy !== 1'b0) begin
        n_fail++; $display("FAIL rr[%0d]: got gnt=%b q=%h owner=%0d busy=%b required gnt=%b q=%h owner=%0d busy=0",
                           k, gnt, q, owner, busy, eg[k], eq[k], eo[k]);
      end
    end
    req = '0;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || q !== 8'h10 || owner !== 2'd0) begin
      n_fail++; $display("FAIL rr_idle: got gnt=%b q=%h owner=%0d required gnt=0000 q=10 owner=0", gnt, q, owner);
    end
  endtask

  // Pointer starts at 1 here; only client 2 requests.
  task automatic test_single_requester();
    req = 4'b0100; lock = '0;
    for (int k = 0; k < 3; k++) begin
      wd[2] = 8'hA0 + 8'(k);
      step();
      n_cmp++;
      if (gnt !== 4'b0100 || q !== (8'hA0 + 8'(k)) || owner !== 2'd2) begin
        n_fail++; $display("FAIL single[%0d]: got gnt=%b q=%h owner=%0d required gnt=0100 q=%h owner=2",
                           k, gnt, q, owner, 8'hA0 + 8'(k));
      end
    end
    // Pointer is now 3: with everyone requesting, client 3 must win.
    set_default_data();
    req = 4'b1111;
    step();
    n_cmp++;
    if (gnt !== 4'b1000 || q !== 8'h13) begin
      n_fail++; $display("FAIL single_ptr: got gnt=%b q=%h required gnt=1000 q=13", gnt, q);
    end
    req = '0;
    step();
  endtask

  // Pointer starts at 0; client 1 locks while all clients request.
  task automatic test_locked_burst();
    logic [3:0] eg [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    logic [7:0] eq [6] = '{8'h10, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h12};
    logic       eb [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    set_default_data();
    req = 4'b1111; lock = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      wd[1] = 8'hB0 + 8'(k);
      step();
      n_cmp++;
      if (gnt !== eg[k] || q !== eq[k] || busy !== eb[k]) begin
        n_fail++; $display("FAIL burst[%0d]: got gnt=%b q=%h busy=%b required gnt=%b q=%h busy=%b",
                           k, gnt, q, busy, eg[k], eq[k], eb[k]);
      end
    end
    req = '0; lock = '0;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL burst_idle: got gnt=%b busy=%b required gnt=0000 busy=0", gnt, busy);
    end
  endtask

  // Pointer starts at 3; client 0 locks, client 3 is ignored, then wins on release.
  task automatic test_early_release();
    set_default_data();
    req = 4'b0001; lock = 4'b0001; wd[0] = 8'hC0;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || q !== 8'hC0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rel_lock: got gnt=%b q=%h busy=%b required gnt=0001 q=c0 busy=1", gnt, q, busy);
    end
    req = 4'b1001; wd[0] = 8'hC1;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || q !== 8'hC1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rel_hold: got gnt=%b q=%h busy=%b required gnt=0001 q=c1 busy=1", gnt, q, busy);
    end
    req = 4'b1000; lock = '0; wd[0] = 8'hC2;
    step();
    n_cmp++;
    if (gnt !== 4'b1000 || q !== 8'h13 || owner !== 2'd3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rel_switch: got gnt=%b q=%h owner=%0d busy=%b required gnt=1000 q=13 owner=3 busy=0",
                         gnt, q, owner, busy);
    end
    req = '0;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || q !== 8'h13) begin
      n_fail++; $display("FAIL rel_idle: got gnt=%b q=%h required gnt=0000 q=13", gnt, q);
    end
  endtask

  // Reset arriving in the middle of a locked burst.
  task automatic test_reset_mid_burst();
    req = 4'b0100; lock = 4'b0100; wd[2] = 8'hD0;
    step();
    n_cmp++;
    if (gnt !== 4'b0100 || q !== 8'hD0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_lock: got gnt=%b q=%h busy=%b required gnt=0100 q=d0 busy=1", gnt, q, busy);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, q, owner, busy} !== 15'd0) begin
      n_fail++; $display("FAIL midrst_async: got gnt=%b q=%h owner=%0d busy=%b required all 0", gnt, q, owner, busy);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h00) begin
      n_fail++; $display("FAIL midrst_hold: got gnt=%b busy=%b q=%h required gnt=0000 busy=0 q=00", gnt, busy, q);
    end
    req = '0; lock = '0;
    rst_n = 1'b1;
    step();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    req = 4'b0001; lock = '0;
    repeat (10) step();
    n_cmp++;
    if (wr_cnt !== 16'd10) begin
      n_fail++; $display("FAIL stats_10: got %0d required 10", wr_cnt);
    end
    repeat (65525) step();
    n_cmp++;
    if (wr_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL stats_max: got %h required ffff", wr_cnt);
    end
    repeat (3) step();
    n_cmp++;
    if (wr_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL stats_sat: got %h required ffff", wr_cnt);
    end
    req = '0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_requester();
    test_locked_burst();
    test_early_release();
    test_reset_mid_burst();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
Round-robin arbiter that shares one DW-bit holding register, a bank of asynchronously-reset D flip-flops, between NUM_REQ requesters.
- Each clock edge it picks at most one requesting client and captures that client's write data into the register.
- It reports the winner with a one-hot grant on the following cycle.
- A client may lock the register for a short burst of back-to-back writes.
- Sits between several producer blocks and a single shared status/data register.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 8, data width of each requester and of the shared register
MAX_BURST, 4, maximum consecutive writes per locked ownership (>=1)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rstn  input  1  asynchronous active-low reset
i_req  input  NUM_REQ  level request per client; high = wdata valid, wants a write
i_lock  input  NUM_REQ  per-client lock request, sampled only with i_req
i_wdata  input  NUM_REQ*DW  packed write data, client n at bits [n*DW +: DW]
o_gnt  output  NUM_REQ  one-hot, registered; bit n high = client n's data written at the previous edge
o_q  output  DW  shared register contents
o_owner  output  clog2(NUM_REQ)  index of the last client written
o_busy  output  1  high while the FSM is in LOCKED

Behaviour:
- Reset (i_rstn low, asynchronous, takes effect immediately):
  - o_gnt=0, o_q=0, o_owner=0, o_busy=0.
  - Internal pointer ptr=0, burst count bcnt=0, state=IDLE.
  - Reset mid-burst aborts the lock; no write completes.
- States: IDLE and LOCKED.
- IDLE, at each edge:
  - Search clients ptr, ptr+1, ... wrapping mod NUM_REQ; the first with i_req high wins (w).
  - o_q<=wdata[w], o_gnt<=onehot(w), o_owner<=w.
  - If i_lock[w]=1 and MAX_BURST>1: state<=LOCKED, bcnt<=1, ptr unchanged.
  - Otherwise: ptr<=(w+1) mod NUM_REQ.
  - No request: o_gnt<=0; o_q, o_owner, ptr hold.
- LOCKED (owner=o_owner), at each edge:
  - If i_req[owner] & i_lock[owner] & bcnt<MAX_BURST-1: write owner's data, o_gnt<=onehot(owner), bcnt<=bcnt+1, stay LOCKED.
  - If i_req[owner] & i_lock[owner] & bcnt==MAX_BURST-1: final write by owner, state<=IDLE, ptr<=owner+1, bcnt<=0.
  - If i_req[owner] high but i_lock[owner] low: one last unlocked write by owner, state<=IDLE, ptr<=owner+1.
  - If i_req[owner] low: release. No owner write; perform the normal IDLE search from owner+1 in the same edge (may grant another client); state<=IDLE unless that winner locks.
  - Other clients' requests are ignored while LOCKED.
- Latency and handshake:
  - Data is written at the edge where the client wins; o_gnt is high for exactly the following cycle.
  - A client with i_req held high across its grant cycle is eligible again at the next edge. Clients must deassert i_req or present new data while their o_gnt is high.
- Fairness: an unlocked client cannot win twice in a row while another client is requesting. Worst-case wait is (NUM_REQ-1)*MAX_BURST writes.
- o_busy is a registered copy of state==LOCKED.
- At most one o_gnt bit is high in any cycle.

Optional Feature:
ARB_STATS_EN
- Defined:
  - Adds output o_wr_cnt, 16 bits, reset to 0.
  - Increments by 1 on every edge that writes the register; saturates at 16'hFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset check: assert i_rstn=0 mid-cycle with i_req=4'b1111 -> o_gnt=0, o_q=0, o_owner=0, o_busy=0 immediately, and no grant while reset is held.
- Round-robin: i_req=4'b1111, no lock, client n data=8'h10+n -> o_gnt sequence 0001,0010,0100,1000,0001; o_q 8'h10,11,12,13,10, each lagging one cycle as specified.
- Single requester: only i_req[2]=1 held for 3 edges -> o_gnt=0100 for 3 cycles, o_q follows i_wdata[2] each edge, ptr=3 afterwards.
- Locked burst: client 1 with req=1, lock=1 while others request, MAX_BURST=4 -> four consecutive o_gnt=0010 with o_busy=1 for the first three, then client 2 is granted next.
- Early release: client 0 locks, then drops i_req after 2 writes while client 3 requests -> client 3 granted at the release edge, o_busy falls, no extra client-0 write.
- Stats (ARB_STATS_EN): after 10 grants o_wr_cnt=10; with the counter forced near 16'hFFFF and 3 more writes -> o_wr_cnt stays 16'hFFFF.
